// File: rtl/stream_demux_1to2.sv
// Registered 1:2 stream demux: steers each input word to channel in_sel through a one-entry slot.
// Latency 1 cycle accept-to-valid; in_ready drops only when the selected slot is full and not draining.
module stream_demux_1to2 #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      state0_q, state0_d;
    slot_state_t      state1_q, state1_d;
    logic [WIDTH-1:0] data0_q, data0_d;
    logic [WIDTH-1:0] data1_q, data1_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic             accept;
    logic             load0;
    logic             load1;

    always_comb begin
        state0_d = state0_q;
        state1_d = state1_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;

        // Readiness looks only at the addressed slot, so a stalled channel never blocks the other.
        if (in_sel) begin
            in_ready = !rst && ((state1_q == EMPTY) || out1_ready);
        end else begin
            in_ready = !rst && ((state0_q == EMPTY) || out0_ready);
        end
        accept = in_valid && in_ready;
        load0  = accept && !in_sel;
        load1  = accept && in_sel;

        if (load0) begin
            state0_d = FULL;
            data0_d  = in_data;
            cnt0_d   = cnt0_q + CNT_W'(1);
        end else if ((state0_q == FULL) && out0_ready) begin
            state0_d = EMPTY;
        end

        if (load1) begin
            state1_d = FULL;
            data1_d  = in_data;
            cnt1_d   = cnt1_q + CNT_W'(1);
        end else if ((state1_q == FULL) && out1_ready) begin
            state1_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state0_q <= EMPTY;
            state1_q <= EMPTY;
            data0_q  <= '0;
            data1_q  <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
            data0_q  <= data0_d;
            data1_q  <= data1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    assign out0_valid = (state0_q == FULL);
    assign out1_valid = (state1_q == FULL);
    assign out0_data  = data0_q;
    assign out1_data  = data1_q;
    assign cnt0       = cnt0_q;
    assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Randomized plus directed bench for stream_demux_1to2 with a queue-based scoreboard per channel.
module tb_stream_demux_1to2;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    stream_demux_1to2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: each queue holds the word currently owed on that channel.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic [CNT_W-1:0] mcnt0;
    logic [CNT_W-1:0] mcnt1;
    int               n_cmp;
    int               n_bad;
    logic             last_ready;

    task automatic chk(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: valid must track model occupancy; each handshake pops and compares the owed word.
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_w;
        chk("out0_valid", int'(out0_valid), int'(q0.size() != 0));
        chk("out1_valid", int'(out1_valid), int'(q1.size() != 0));
        chk("cnt0", int'(cnt0), int'(mcnt0));
        chk("cnt1", int'(cnt1), int'(mcnt1));
        if (out0_valid === 1'b1 && out0_ready) begin
            if (q0.size() == 0) begin
                chk("out0_unexpected_word", 1, 0);
            end else begin
                exp_w = q0.pop_front();
                chk("out0_data", int'(out0_data), int'(exp_w));
            end
        end
        if (out1_valid === 1'b1 && out1_ready) begin
            if (q1.size() == 0) begin
                chk("out1_unexpected_word", 1, 0);
            end else begin
                exp_w = q1.pop_front();
                chk("out1_data", int'(out1_data), int'(exp_w));
            end
        end
    end

    // One clock of stimulus; model update runs just after the monitor so drained slots read as free.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic s,
                        input logic r0, input logic r1);
        logic exp_rdy;
        in_valid   = v;
        in_data    = d;
        in_sel     = s;
        out0_ready = r0;
        out1_ready = r1;
        @(negedge clk);
        #1;
        last_ready = in_ready;
        exp_rdy = !rst && (s ? (q1.size() == 0) : (q0.size() == 0));
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        if (rst) begin
            q0.delete();
            q1.delete();
            mcnt0 = '0;
            mcnt1 = '0;
        end else if (v && exp_rdy) begin
            if (s) begin
                q1.push_back(d);
                mcnt1 = mcnt1 + 1'b1;
            end else begin
                q0.push_back(d);
                mcnt0 = mcnt0 + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mcnt0 = '0;
        mcnt1 = '0;
        last_ready = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_sel = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_in_ready", int'(last_ready), 0);
        chk("rst_out0_data", int'(out0_data), 0);
        chk("rst_out1_data", int'(out1_data), 0);
        rst = 1'b0;

        // Single word to channel 0 with consumer stalled.
        step(1'b1, 4'd13, 1'b0, 1'b0, 1'b0);
        chk("t1_out0_valid", int'(out0_valid), 1);
        chk("t1_out0_data", int'(out0_data), 13);
        chk("t1_cnt0", int'(cnt0), 1);
        chk("t1_out1_valid", int'(out1_valid), 0);
        chk("t1_cnt1", int'(cnt1), 0);

        // Blocked on channel 0, then steered to the free channel 1.
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        chk("t2_blocked_ready", int'(last_ready), 0);
        chk("t2_out0_hold", int'(out0_data), 13);
        step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
        chk("t2_other_ready", int'(last_ready), 1);
        chk("t2_out1_data", int'(out1_data), 3);
        chk("t2_out1_valid", int'(out1_valid), 1);
        chk("t2_cnt1", int'(cnt1), 1);
        chk("t2_out0_still", int'(out0_data), 13);

        // Back-to-back streaming with both consumers ready.
        do_reset();
        begin
            logic [WIDTH-1:0] words [4];
            logic             sels  [4];
            words = '{4'd11, 4'd3, 4'd10, 4'd12};
            sels  = '{1'b0, 1'b1, 1'b1, 1'b0};
            for (int i = 0; i < 4; i++) begin
                step(1'b1, words[i], sels[i], 1'b1, 1'b1);
                chk("t3_ready", int'(last_ready), 1);
                chk("t3_data", int'(sels[i] ? out1_data : out0_data), int'(words[i]));
            end
        end
        chk("t3_cnt0", int'(cnt0), 2);
        chk("t3_cnt1", int'(cnt1), 2);

        // Drain and load on channel 1 in the same cycle.
        step(1'b1, 4'd7, 1'b1, 1'b0, 1'b1);
        chk("t4_ready", int'(last_ready), 1);
        chk("t4_out1_valid", int'(out1_valid), 1);
        chk("t4_out1_data", int'(out1_data), 7);
        chk("t4_cnt1", int'(cnt1), 3);

        // Counter wrap on channel 0.
        do_reset();
        for (int i = 0; i < 255; i++) begin
            step(1'b1, WIDTH'($urandom), 1'b0, 1'b1, 1'b1);
        end
        chk("t5_cnt0_pre", int'(cnt0), 255);
        step(1'b1, 4'd1, 1'b0, 1'b1, 1'b1);
        chk("t5_cnt0_wrap", int'(cnt0), 0);
        chk("t5_out0_data", int'(out0_data), 1);

        // Reset with both slots full.
        step(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        chk("t6_both_full", int'(out0_valid && out1_valid), 1);
        rst = 1'b1;
        step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_ready", int'(last_ready), 0);
        chk("t6_out0_valid", int'(out0_valid), 0);
        chk("t6_out1_valid", int'(out1_valid), 0);
        chk("t6_out0_data", int'(out0_data), 0);
        chk("t6_out1_data", int'(out1_data), 0);
        chk("t6_cnt0", int'(cnt0), 0);
        chk("t6_cnt1", int'(cnt1), 0);
        rst = 1'b0;

        // Random traffic with occasional mid-stream resets.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            step(1'($urandom), WIDTH'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        end
        chk("final_out0_empty", int'(out0_valid), 0);
        chk("final_out1_empty", int'(out1_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
